seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment display driver (hex digits 0-F, per-digit decimal point).
//  Successor to the single-digit hex decoder: adds digit scanning, double-buffered load,
//  per-digit blanking, leading-zero suppression and anti-ghosting dead time.
//  Sits between system logic and the board display pins; segments/anodes/DP all active low.
// PARAMETERS
//  DIGITS        4      number of digits scanned, 1..8
//  SCAN_DIV      100000 Clock cycles per digit slot, >= 2
//  GHOST_CYCLES  1000   cycles at slot start with all anodes off, 0..SCAN_DIV-1
// PORTS
//  Clock       in   1          system clock
//  Reset       in   1          synchronous, active-high
//  Enable      in   1          1 = scan; 0 = display dark
//  Load        in   1          1-cycle strobe: capture Value/DpIn/BlankMask into pending buffer
//  Value       in   4*DIGITS   nibble i = digit i; digit 0 is rightmost
//  DpIn        in   DIGITS     1 = light DP of digit i
//  BlankMask   in   DIGITS     1 = force digit i blank (segments and DP off)
//  LzSuppress  in   1          1 = blank leading zero digits (live input, not buffered)
//  Leds        out  [0:6]      segments a..g = Leds[0]..Leds[6], active low
//  Dp          out  1          decimal point, active low
//  Anodes      out  DIGITS     Anodes[i] low = digit i on
// BEHAVIOUR
//  Reset (takes priority over all inputs): Leds=7'b111_1111, Dp=1, Anodes all 1;
//   prescaler=0, digit index=0; pending and active buffers cleared (Value=0, DpIn=0, BlankMask=0).
//  All outputs registered. Counter state at edge k is visible on the pins after edge k+1.
//  Prescaler counts 0..SCAN_DIV-1, then wraps to 0 and advances the digit index.
//  Digit index counts 0..DIGITS-1, then wraps to 0; that wrap is the frame end.
//  Within a slot:
//   - prescaler < GHOST_CYCLES: Anodes all 1; Leds and Dp all 1.
//   - otherwise: Anodes has only bit [digit index] low; Leds = hex decode of the active nibble.
//  Hex decode patterns (a..g, active low):
//   0 0000001   1 1001111   2 0010010   3 0000110
//   4 1001100   5 0100100   6 0100000   7 0001111
//   8 0000000   9 0000100   A 0001000   b 1100000
//   C 0110001   d 1000010   E 0110000   F 0111000
//  Double buffer:
//   - Load writes the pending buffer. With several Loads in one frame, the last one wins.
//   - Pending -> active transfer happens on the frame-end cycle
//     (prescaler = SCAN_DIV-1 and index = DIGITS-1). The display never tears mid-frame.
//   - Load on the frame-end cycle itself goes straight into active (bypass).
//  Blanking, with digit i shown:
//   - BlankMask[i] = 1: Leds = 7'b111_1111 and Dp = 1; the anode still cycles.
//   - Leading-zero suppression: with LzSuppress = 1, digit i is blanked when i > 0 and
//     active nibbles i..DIGITS-1 are all zero. Digit 0 is never zero-suppressed.
//     A DP on a suppressed digit stays lit.
//   - Dp = ~DpIn_active[i] unless the digit is masked or in dead time.
//  Enable = 0:
//   - Prescaler and index are held at 0.
//   - Outputs become all 1 on the next edge.
//   - Pending is copied to active every cycle.
//   - On re-enable, scanning restarts at digit 0, slot start (dead time first).
//  Reset mid-frame: everything returns to reset values at the next edge; no partial transfer.
//  DIGITS = 1: index stays 0; every slot end is a frame end.
// TESTING (DIGITS=4, SCAN_DIV=4, GHOST_CYCLES=1)
//  1. Reset, then Load Value=16'h12AF, Enable=1:
//     -> after first frame end, Anodes cycle 1111,1110x3, 1111,1101x3, ... digit0 Leds=0111000 (F).
//  2. Load 16'h0000, then 16'h0042 in the same frame:
//     -> the next frame shows only 0042; no slot shows 0000 or a mix.
//  3. Active value 16'h0042, LzSuppress=1:
//     -> digits 3,2 Leds=1111111; digit1=1001100, digit0=0010010.
//     Value 0 -> only digit0 lit, showing 0000001.
//  4. BlankMask=4'b0100, DpIn=4'b0101:
//     -> digit2 Leds=1111111 and Dp=1; digit0 Dp=0; Anodes pattern unchanged.
//  5. Enable dropped mid-slot of digit2:
//     -> next edge all outputs 1; on re-enable, first lit slot is digit0 after 1 dead cycle.
//  6. Reset asserted mid-frame with pending load:
//     -> outputs 1s next edge, active and pending = 0; after release, digit0 shows 0000001.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed N-digit hex display driver with double buffering
module seven_seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GHOST_CYCLES = 1000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     DpIn,
    input  logic [DIGITS-1:0]     BlankMask,
    input  logic                  LzSuppress,
    output logic [0:6]            Leds,
    output logic                  Dp,
    output logic [DIGITS-1:0]     Anodes
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       pre;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] pend_val, act_val;
    logic [DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank, lz;
    logic                slot_end, frame_end, dead, blank, all_zero;
    logic [3:0]          nib;
    logic [0:6]          seg;

    assign slot_end  = pre == PW'(SCAN_DIV - 1);
    assign frame_end = slot_end && idx == IW'(DIGITS - 1);
    assign dead      = int'(pre) < GHOST_CYCLES;
    assign nib       = act_val[{idx, 2'b00} +: 4];
    assign blank     = act_blank[idx] | (LzSuppress & lz[idx]);

    // Hex nibble to active-low a..g pattern
    always_comb begin
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 never is
    always_comb begin
        lz = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero & (act_val[4*i +: 4] == 4'h0);
            lz[i] = all_zero;
        end
    end

    // Pending buffer takes every Load; active only changes at frame end or while dark, so no tearing
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
        end else begin
            if (Load) begin
                pend_val   <= Value;
                pend_dp    <= DpIn;
                pend_blank <= BlankMask;
            end
            if (!Enable || frame_end) begin
                act_val   <= Load ? Value : pend_val;
                act_dp    <= Load ? DpIn : pend_dp;
                act_blank <= Load ? BlankMask : pend_blank;
            end
        end
    end

    // Slot prescaler and digit index, parked at digit 0 slot start while disabled
    always_ff @(posedge Clock) begin
        if (Reset || !Enable) begin
            pre <= '0;
            idx <= '0;
        end else if (slot_end) begin
            pre <= '0;
            idx <= frame_end ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Registered pins: dark while disabled or in dead time, masked/suppressed digits blank
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Leds   <= '1;
            Dp     <= 1'b1;
            Anodes <= '1;
        end else begin
            Leds   <= (!Enable || dead || blank) ? '1 : seg;
            Dp     <= (!Enable || dead || act_blank[idx]) ? 1'b1 : ~act_dp[idx];
            Anodes <= (!Enable || dead) ? '1 : ~(DIGITS'(1) << idx);
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed checks of scanning, buffering, blanking and enable/reset
module tb_seven_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_suppress = 1'b0;
    logic [0:6]  leds;
    logic        dp;
    logic [3:0]  anodes;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [6:0] BLK = 7'b1111111;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .GHOST_CYCLES(1)) dut (
        .Clock(clk), .Reset(rst), .Enable(enable), .Load(load), .Value(value),
        .DpIn(dp_in), .BlankMask(blank_mask), .LzSuppress(lz_suppress),
        .Leds(leds), .Dp(dp), .Anodes(anodes)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        vectors++;
        if (leds !== BLK) begin miscompares++; $display("FAIL reset_leds got %b want %b", leds, BLK); end
        vectors++;
        if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got %b want 1", dp); end
        vectors++;
        if (anodes !== 4'b1111) begin miscompares++; $display("FAIL reset_anodes got %b want 1111", anodes); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        logic [3:0] ea;
        logic [6:0] el;
        rst = 1'b0;
        enable = 1'b1;
        load = 1'b1;
        value = 16'h12AF;
        tick(1);
        load = 1'b0;
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK) begin
            miscompares++; $display("FAIL scan_first_dead anodes=%b leds=%b want 1111 %b", anodes, leds, BLK);
        end
        tick(1);
        vectors++;
        if (anodes !== 4'b1110 || leds !== 7'b0000001) begin
            miscompares++; $display("FAIL scan_pre_transfer anodes=%b leds=%b want 1110 0000001", anodes, leds);
        end
        tick(14);
        for (int c = 0; c < 16; c++) begin
            tick(1);
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : exp_seg[c / 4];
            vectors++;
            if (anodes !== ea || leds !== el || dp !== 1'b1) begin
                miscompares++; $display("FAIL scan c=%0d anodes=%b leds=%b dp=%b want %b %b 1", c, anodes, leds, dp, ea, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] old_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        logic [6:0] new_seg [4] = '{7'b0010010, 7'b1001100, 7'b0000001, 7'b0000001};
        logic [3:0] ea;
        logic [6:0] el;
        for (int c = 0; c < 16; c++) begin
            load = (c == 0 || c == 7);
            value = (c == 7) ? 16'h0042 : 16'h0000;
            tick(1);
            load = 1'b0;
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : old_seg[c / 4];
            vectors++;
            if (anodes !== ea || leds !== el) begin
                miscompares++; $display("FAIL b2b_hold c=%0d anodes=%b leds=%b want %b %b", c, anodes, leds, ea, el);
            end
        end
        for (int c = 0; c < 16; c++) begin
            tick(1);
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : new_seg[c / 4];
            vectors++;
            if (anodes !== ea || leds !== el) begin
                miscompares++; $display("FAIL b2b_new c=%0d anodes=%b leds=%b want %b %b", c, anodes, leds, ea, el);
            end
        end
    endtask

    task automatic test_lz_suppress();
        logic [6:0] s42 [4] = '{7'b0010010, 7'b1001100, BLK, BLK};
        logic [6:0] s0 [4] = '{7'b0000001, BLK, BLK, BLK};
        logic [3:0] ea;
        logic [6:0] el;
        lz_suppress = 1'b1;
        for (int c = 0; c < 16; c++) begin
            load = (c == 0);
            value = 16'h0000;
            tick(1);
            load = 1'b0;
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : s42[c / 4];
            vectors++;
            if (anodes !== ea || leds !== el) begin
                miscompares++; $display("FAIL lz_0042 c=%0d anodes=%b leds=%b want %b %b", c, anodes, leds, ea, el);
            end
        end
        for (int c = 0; c < 16; c++) begin
            tick(1);
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : s0[c / 4];
            vectors++;
            if (anodes !== ea || leds !== el) begin
                miscompares++; $display("FAIL lz_zero c=%0d anodes=%b leds=%b want %b %b", c, anodes, leds, ea, el);
            end
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_blank_dp();
        logic [6:0] sb [4] = '{7'b0111000, 7'b0001000, BLK, 7'b1001111};
        logic       db [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] ea;
        logic [6:0] el;
        logic       ed;
        for (int c = 0; c < 16; c++) begin
            load = (c == 0);
            value = 16'h12AF;
            blank_mask = 4'b0100;
            dp_in = 4'b0101;
            tick(1);
            load = 1'b0;
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : 7'b0000001;
            vectors++;
            if (anodes !== ea || leds !== el || dp !== 1'b1) begin
                miscompares++; $display("FAIL blank_hold c=%0d anodes=%b leds=%b dp=%b want %b %b 1", c, anodes, leds, dp, ea, el);
            end
        end
        for (int c = 0; c < 16; c++) begin
            tick(1);
            ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << (c / 4));
            el = (c % 4 == 0) ? BLK : sb[c / 4];
            ed = (c % 4 == 0) ? 1'b1 : db[c / 4];
            vectors++;
            if (anodes !== ea || leds !== el || dp !== ed) begin
                miscompares++; $display("FAIL blank_dp c=%0d anodes=%b leds=%b dp=%b want %b %b %b", c, anodes, leds, dp, ea, el, ed);
            end
        end
    endtask

    task automatic test_bypass();
        tick(15);
        load = 1'b1;
        value = 16'h3333;
        blank_mask = 4'b0000;
        dp_in = 4'b0000;
        tick(1);
        load = 1'b0;
        tick(1);
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK) begin
            miscompares++; $display("FAIL bypass_dead anodes=%b leds=%b want 1111 %b", anodes, leds, BLK);
        end
        tick(1);
        vectors++;
        if (anodes !== 4'b1110 || leds !== 7'b0000110 || dp !== 1'b1) begin
            miscompares++; $display("FAIL bypass anodes=%b leds=%b dp=%b want 1110 0000110 1", anodes, leds, dp);
        end
    endtask

    task automatic test_enable();
        tick(8);
        vectors++;
        if (anodes !== 4'b1011 || leds !== 7'b0000110) begin
            miscompares++; $display("FAIL en_digit2 anodes=%b leds=%b want 1011 0000110", anodes, leds);
        end
        enable = 1'b0;
        tick(1);
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK || dp !== 1'b1) begin
            miscompares++; $display("FAIL en_off anodes=%b leds=%b dp=%b want 1111 %b 1", anodes, leds, dp, BLK);
        end
        load = 1'b1;
        value = 16'h0005;
        tick(1);
        load = 1'b0;
        tick(1);
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK) begin
            miscompares++; $display("FAIL en_dark anodes=%b leds=%b want 1111 %b", anodes, leds, BLK);
        end
        enable = 1'b1;
        tick(1);
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK) begin
            miscompares++; $display("FAIL en_restart_dead anodes=%b leds=%b want 1111 %b", anodes, leds, BLK);
        end
        tick(1);
        vectors++;
        if (anodes !== 4'b1110 || leds !== 7'b0100100) begin
            miscompares++; $display("FAIL en_restart_digit0 anodes=%b leds=%b want 1110 0100100", anodes, leds);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1;
        value = 16'h7777;
        tick(1);
        load = 1'b0;
        rst = 1'b1;
        tick(1);
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK || dp !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_dark anodes=%b leds=%b dp=%b want 1111 %b 1", anodes, leds, dp, BLK);
        end
        rst = 1'b0;
        tick(1);
        vectors++;
        if (anodes !== 4'b1111 || leds !== BLK) begin
            miscompares++; $display("FAIL rstmid_dead anodes=%b leds=%b want 1111 %b", anodes, leds, BLK);
        end
        tick(1);
        vectors++;
        if (anodes !== 4'b1110 || leds !== 7'b0000001) begin
            miscompares++; $display("FAIL rstmid_active anodes=%b leds=%b want 1110 0000001", anodes, leds);
        end
        tick(16);
        vectors++;
        if (anodes !== 4'b1110 || leds !== 7'b0000001) begin
            miscompares++; $display("FAIL rstmid_pending anodes=%b leds=%b want 1110 0000001", anodes, leds);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_back_to_back();
        test_lz_suppress();
        test_blank_dp();
        test_bypass();
        test_enable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
